// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a network pass layer by layer over the shared input_node_timer.
// Optional RUN watchdog is enabled by defining LAYER_SEQ_WDOG_EN.
module layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int CNT_W      = 7
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_layer,
  input  logic [CNT_W-1:0]   cfg_size,
  input  logic [LAYER_W:0]   num_layers,
  input  logic               start,
  input  logic               abort,
  input  logic               coef_ready,
  input  logic               n_start_done,
  output logic [CNT_W-1:0]   max_input,
  output logic               timer_clr,
  output logic               coef_req,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               net_done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [LAYER_W:0]   MAX_L = (LAYER_W+1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0]   N_ONE = (LAYER_W+1)'(1);
  localparam logic [LAYER_W-1:0] L_ONE = LAYER_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   tbl [MAX_LAYERS];
  logic [LAYER_W:0]   num_q;
  logic               run_first;
  logic               start_ok;
  logic               last_layer;
  logic               wd_hit;

  assign start_ok   = start && (num_layers != '0) && (num_layers <= MAX_L);
  assign last_layer = ({1'b0, layer_idx} == (num_q - N_ONE));

`ifdef LAYER_SEQ_WDOG_EN
  localparam logic [CNT_W+1:0] WD_ONE = (CNT_W+2)'(1);
  localparam logic [CNT_W+1:0] WD_OFS = (CNT_W+2)'(8);
  logic [CNT_W+1:0] wd_cnt;
  logic [CNT_W+1:0] wd_limit;

  assign wd_limit = {1'b0, max_input, 1'b0} + WD_OFS;
  assign wd_hit   = (state == S_RUN) && ((wd_cnt + WD_ONE) == wd_limit);

  // Zero outside RUN, so every entry into RUN starts a fresh count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)              wd_cnt <= '0;
    else if (state == S_RUN) wd_cnt <= wd_cnt + WD_ONE;
    else                     wd_cnt <= '0;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < MAX_LAYERS; i++) tbl[i] <= '0;
    end else if (cfg_we && !busy) begin
      tbl[cfg_layer] <= cfg_size;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      num_q     <= '0;
      run_first <= 1'b0;
      max_input <= '0;
      timer_clr <= 1'b0;
      coef_req  <= 1'b0;
      layer_idx <= '0;
      busy      <= 1'b0;
      net_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      timer_clr <= 1'b0;
      net_done  <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        timer_clr <= 1'b1;
        coef_req  <= 1'b0;
        err       <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (start_ok) begin
              num_q     <= num_layers;
              layer_idx <= '0;
              err       <= 1'b0;
              busy      <= 1'b1;
              timer_clr <= 1'b1;
              state     <= S_LOAD;
            end else if (start && state == S_IDLE) begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
          // timer_clr is raised on the edge into LOAD so it is seen during LOAD;
          // the table is read on the way out so a coincident cfg write is picked up.
          S_LOAD: begin
            max_input <= tbl[layer_idx];
            if (tbl[layer_idx] == '0) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else begin
              coef_req <= 1'b1;
              state    <= S_REQ;
            end
          end
          S_REQ: begin
            if (coef_ready) begin
              coef_req  <= 1'b0;
              run_first <= 1'b1;
              state     <= S_RUN;
            end
          end
          S_RUN: begin
            run_first <= 1'b0;
            if (!coef_ready) begin
              coef_req <= 1'b1;
              state    <= S_REQ;
            end else if (n_start_done && !run_first) begin
              state <= S_NEXT;
            end else if (wd_hit) begin
              err       <= 1'b1;
              busy      <= 1'b0;
              timer_clr <= 1'b1;
              state     <= S_ERR;
            end
          end
          S_NEXT: begin
            if (last_layer) begin
              busy     <= 1'b0;
              net_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              layer_idx <= layer_idx + L_ONE;
              timer_clr <= 1'b1;
              state     <= S_LOAD;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
